des_round_ctrl: RTL

Iterative DES round controller that owns the L/R half-block registers and steps them through the Feistel rounds.
- Presents R to the expansion permutation every round.
- Supplies the subkey index to the key schedule.
- Folds the returned f-function result back into L/R.
- Sits between the initial permutation (upstream) and the final permutation (downstream).

---
 rtl/des_round_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// -----------------------------------------------------------------------------
// des_round_ctrl
//
// Iterative DES round controller. Owns the L/R half-block registers and walks
// them through ROUNDS Feistel rounds, one round per (F_LAT+1) clock cycles.
// The external datapath (E-expansion, key XOR, S-boxes, P) takes r_out and the
// subkey selected by round_idx, and returns f(R, K) on f_in. The controller
// folds that result back into L/R. It sits between the initial permutation
// (upstream) and the final permutation (downstream).
//
// Parameters:
//   ROUNDS  number of Feistel rounds, even, 2..16
//   F_LAT   register stages inside the external f-function path, 0..3
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous active-high reset
//   start      load request, honoured only while ready=1
//   decrypt    direction, sampled with start (1 = reverse subkey order)
//   data_in    post-IP block, L0 = [63:32], R0 = [31:0]
//   f_in       f(R, K) result for the current round
//   ready      idle, a start will be accepted
//   busy       block in progress (ROUND or DONE)
//   r_out      current R register, drives the E-expansion input
//   round_idx  subkey index for the key schedule
//   done       one-cycle pulse, data_out valid
//   data_out   {R_final, L_final}, input to the final permutation
// -----------------------------------------------------------------------------
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int F_LAT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  input  logic [31:0] f_in,
  output logic        ready,
  output logic        busy,
  output logic [31:0] r_out,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic [63:0] data_out
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (ROUNDS < 2 || ROUNDS > 16 || (ROUNDS % 2) != 0) begin : g_bad_rounds
      $error("des_round_ctrl: ROUNDS must be even and within 2..16");
    end
    if (F_LAT < 0 || F_LAT > 3) begin : g_bad_flat
      $error("des_round_ctrl: F_LAT must be within 0..3");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] LAST_RND  = 4'(ROUNDS - 1);
  localparam logic [1:0] WAIT_INIT = 2'(F_LAT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_reg, state_next;
  logic [31:0] l_reg,     l_next;
  logic [31:0] r_reg,     r_next;
  logic [3:0]  rnd_reg,   rnd_next;
  logic [1:0]  wcnt_reg,  wcnt_next;
  logic        dec_reg,   dec_next;
  logic [63:0] dout_reg,  dout_next;

  // Feistel fold of the returned f-function result into the left half.
  logic [31:0] fold;
  assign fold = l_reg ^ f_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    l_next     = l_reg;
    r_next     = r_reg;
    rnd_next   = rnd_reg;
    wcnt_next  = wcnt_reg;
    dec_next   = dec_reg;
    dout_next  = dout_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          l_next     = data_in[63:32];
          r_next     = data_in[31:0];
          dec_next   = decrypt;
          rnd_next   = 4'd0;
          wcnt_next  = WAIT_INIT;
          state_next = ROUND;
        end
      end

      ROUND: begin
        if (wcnt_reg != 2'd0) begin
          // f-path still filling: hold L/R so r_out and round_idx stay put
          wcnt_next = wcnt_reg - 2'd1;
        end else begin
          l_next    = r_reg;
          r_next    = fold;
          wcnt_next = WAIT_INIT;
          if (rnd_reg == LAST_RND) begin
            // Last round: the usual final swap is folded in here, so the
            // captured word is {R16, L16} ready for the final permutation.
            dout_next  = {fold, r_reg};
            state_next = DONE;
          end else begin
            rnd_next = rnd_reg + 4'd1;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      l_reg     <= 32'd0;
      r_reg     <= 32'd0;
      rnd_reg   <= 4'd0;
      wcnt_reg  <= 2'd0;
      dec_reg   <= 1'b0;
      dout_reg  <= 64'd0;
    end else begin
      state_reg <= state_next;
      l_reg     <= l_next;
      r_reg     <= r_next;
      rnd_reg   <= rnd_next;
      wcnt_reg  <= wcnt_next;
      dec_reg   <= dec_next;
      dout_reg  <= dout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registers, so glitch-free within a cycle)
  // ---------------------------------------------------------------------------
  assign ready     = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign r_out     = r_reg;
  // Decryption walks the same schedule backwards.
  assign round_idx = dec_reg ? (LAST_RND - rnd_reg) : rnd_reg;
  assign data_out  = dout_reg;

endmodule
